// File: rtl/hidden_cpu_host.sv
// Host-side sequencer for the HiddenCPU tile: it streams a loaded program into the CPU instruction
// pins, follows the CPU's R3/PC output mode and its branches, and queues flagged results in a small FIFO.
module hidden_cpu_host #(
    parameter int          PROG_DEPTH  = 32,
    parameter logic [5:0]  TOGGLE_WORD = 6'b111111,
    parameter logic [5:0]  NOP_WORD    = 6'b000000,
    localparam int         AW          = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [6:0]    load_data,
    input  logic          start,
    input  logic [7:0]    run_len,
    input  logic          abort,
    input  logic [7:0]    cpu_out,
    output logic [5:0]    cpu_instr,
    output logic          cpu_rst,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRST = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [6:0] prog_mem [PROG_DEPTH];
    logic [7:0] shadow_pc;
    logic       sel_pc;
    logic [7:0] remaining;
    logic       cap_pend;
    logic [7:0] fetch_addr;
    logic [6:0] fetch_word;
    logic       cmd_ok;

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       full;

    // In PC mode the CPU's own PC drives the fetch, so taken branches are followed for free.
    assign fetch_addr = sel_pc ? cpu_out : shadow_pc;
    assign fetch_word = prog_mem[fetch_addr[AW-1:0]];
    assign cmd_ok     = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_rst    = 1'b1;
        cpu_instr  = NOP_WORD;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CRST;
            end
            S_CRST: begin
                busy       = 1'b1;
                state_next = (remaining == 8'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_rst   = 1'b0;
                cpu_instr = fetch_word[5:0];
                if (remaining == 8'd1) state_next = S_DONE;
            end
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) state_next = S_CRST;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_pc <= 8'd0;
            sel_pc    <= 1'b0;
            remaining <= 8'd0;
            cap_pend  <= 1'b0;
        end else begin
            cap_pend <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) remaining <= run_len;
                end
                S_CRST: begin
                    shadow_pc <= 8'd0;
                    sel_pc    <= 1'b0;
                end
                S_RUN: begin
                    shadow_pc <= fetch_addr + 8'd1;
                    remaining <= remaining - 8'd1;
                    cap_pend  <= fetch_word[6] & ~abort;
                    // Mirror the CPU's selOut flip-flop so we know what cpu_out means next cycle.
                    if (fetch_word[5:0] == TOGGLE_WORD) sel_pc <= ~sel_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_we && cmd_ok) prog_mem[load_addr] <= load_data;
    end

    // Result FIFO; a push into a full FIFO survives only if the head leaves in the same cycle.
    assign push_req  = cap_pend && ((state == S_RUN) || (state == S_DONE));
    assign full      = (count == 3'd4);
    assign res_valid = (count != 3'd0);
    assign res_data  = fifo_mem[rd_ptr];
    assign pop       = res_valid && res_ready;
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cpu_out;
    end

    always_ff @(posedge clk) begin
        if (rst || (state == S_CRST)) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hidden_cpu_host.sv
// Directed bench for hidden_cpu_host: the CPU output bus is driven by hand and every expected
// instruction, FIFO value and status flag is a hand-computed constant.
module tb_hidden_cpu_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_we = 1'b0;
    logic [4:0] load_addr = '0;
    logic [6:0] load_data = '0;
    logic       start = 1'b0;
    logic [7:0] run_len = '0;
    logic       abort = 1'b0;
    logic [7:0] cpu_out = '0;
    logic [5:0] cpu_instr;
    logic       cpu_rst;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hidden_cpu_host dut (
        .clk       (clk),
        .rst       (rst),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .run_len   (run_len),
        .abort     (abort),
        .cpu_out   (cpu_out),
        .cpu_instr (cpu_instr),
        .cpu_rst   (cpu_rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [6:0] data);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] len);
        start   = 1'b1;
        run_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b want=1", cpu_rst); end
        checks++; if (cpu_instr !== 6'h00) begin errors++; $display("FAIL reset_instr got=%h want=00", cpu_instr); end
        checks++; if ({busy, done, res_valid, overflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {busy, done, res_valid, overflow});
        end
    endtask

    task automatic test_basic_run();
        load_word(5'd0, 7'h45);
        load_word(5'd1, 7'h3F);
        load_word(5'd2, 7'h49);
        start_run(8'd3);
        checks++; if ({cpu_rst, busy, cpu_instr} !== {1'b1, 1'b1, 6'h00}) begin
            errors++; $display("FAIL basic_crst got=%b/%b/%h want=1/1/00", cpu_rst, busy, cpu_instr);
        end
        tick();
        cpu_out = 8'hA1; #1;
        checks++; if ({cpu_rst, cpu_instr} !== {1'b0, 6'h05}) begin
            errors++; $display("FAIL basic_w0 got=%b/%h want=0/05", cpu_rst, cpu_instr);
        end
        tick();
        cpu_out = 8'h11; #1;
        checks++; if (cpu_instr !== 6'h3F) begin errors++; $display("FAIL basic_w1 got=%h want=3f", cpu_instr); end
        tick();
        cpu_out = 8'h02; #1;
        checks++; if (cpu_instr !== 6'h09) begin errors++; $display("FAIL basic_w2_pcmode got=%h want=09", cpu_instr); end
        tick();
        cpu_out = 8'h22; #1;
        checks++; if ({done, busy, cpu_rst, cpu_instr} !== {1'b1, 1'b0, 1'b0, 6'h00}) begin
            errors++; $display("FAIL basic_done got=%b/%b/%b/%h want=1/0/0/00", done, busy, cpu_rst, cpu_instr);
        end
        checks++; if ({res_valid, res_data} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL basic_head0 got=%b/%h want=1/11", res_valid, res_data);
        end
        tick();
        checks++; if ({res_valid, res_data} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL basic_head_stable got=%b/%h want=1/11", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        checks++; if ({res_valid, res_data} !== {1'b1, 8'h22}) begin
            errors++; $display("FAIL basic_head1 got=%b/%h want=1/22", res_valid, res_data);
        end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b want=0", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_empty got=%b want=0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_branch();
        load_word(5'd0, 7'h3F);
        load_word(5'd1, 7'h01);
        load_word(5'd2, 7'h02);
        load_word(5'd7, 7'h3F);
        load_word(5'd8, 7'h08);
        start_run(8'd5);
        tick();
        checks++; if (cpu_instr !== 6'h3F) begin errors++; $display("FAIL branch_w0 got=%h want=3f", cpu_instr); end
        tick();
        cpu_out = 8'd1; #1;
        checks++; if (cpu_instr !== 6'h01) begin errors++; $display("FAIL branch_pc1 got=%h want=01", cpu_instr); end
        tick();
        cpu_out = 8'd2; #1;
        checks++; if (cpu_instr !== 6'h02) begin errors++; $display("FAIL branch_pc2 got=%h want=02", cpu_instr); end
        tick();
        cpu_out = 8'd7; #1;
        checks++; if (cpu_instr !== 6'h3F) begin errors++; $display("FAIL branch_jump7 got=%h want=3f", cpu_instr); end
        tick();
        cpu_out = 8'hEE; #1;
        checks++; if (cpu_instr !== 6'h08) begin errors++; $display("FAIL branch_shadow8 got=%h want=08", cpu_instr); end
        tick();
        checks++; if ({done, res_valid} !== 2'b10) begin
            errors++; $display("FAIL branch_done got=%b want=10", {done, res_valid});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) load_word(5'(i), 7'h50 + 7'(i));
        start_run(8'd5);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            cpu_out = 8'hC0 + 8'(i);
        end
        tick();
        checks++; if ({done, overflow, res_valid} !== 3'b111) begin
            errors++; $display("FAIL ovf_flags got=%b want=111", {done, overflow, res_valid});
        end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({res_valid, res_data} !== {1'b1, 8'hC0 + 8'(i)}) begin
                errors++; $display("FAIL ovf_pop%0d got=%b/%h want=1/%h", i, res_valid, res_data, 8'hC0 + 8'(i));
            end
            tick();
        end
        checks++; if ({res_valid, overflow} !== 2'b01) begin
            errors++; $display("FAIL ovf_drained got=%b want=01", {res_valid, overflow});
        end
        res_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        start_run(8'd5);
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_cleared got=%b want=0", overflow); end
        for (int i = 0; i < 5; i++) begin
            tick();
            cpu_out = 8'hD0 + 8'(i);
            if (i == 4) res_ready = 1'b1;
        end
        tick();
        checks++; if ({overflow, res_valid, res_data} !== {1'b0, 1'b1, 8'hD1}) begin
            errors++; $display("FAIL fullpop_head got=%b/%b/%h want=0/1/d1", overflow, res_valid, res_data);
        end
        for (int i = 2; i < 5; i++) begin
            tick();
            checks++; if ({res_valid, res_data} !== {1'b1, 8'hD0 + 8'(i)}) begin
                errors++; $display("FAIL fullpop_pop%0d got=%b/%h want=1/%h", i, res_valid, res_data, 8'hD0 + 8'(i));
            end
        end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%b want=0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        load_word(5'd0, 7'h01);
        load_word(5'd1, 7'h02);
        load_word(5'd2, 7'h03);
        start_run(8'd3);
        tick();
        checks++; if (cpu_instr !== 6'h01) begin errors++; $display("FAIL abort_w0 got=%h want=01", cpu_instr); end
        tick();
        checks++; if (cpu_instr !== 6'h02) begin errors++; $display("FAIL abort_w1 got=%h want=02", cpu_instr); end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++; if ({cpu_rst, cpu_instr, busy, done} !== {1'b1, 6'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL abort_idle got=%b/%h/%b/%b want=1/00/0/0", cpu_rst, cpu_instr, busy, done);
        end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_stays_idle got=%b want=00", {busy, done}); end
        start_run(8'd0);
        checks++; if ({busy, cpu_rst, done} !== 3'b110) begin
            errors++; $display("FAIL zero_len_crst got=%b want=110", {busy, cpu_rst, done});
        end
        tick();
        checks++; if ({busy, cpu_rst, done} !== 3'b001) begin
            errors++; $display("FAIL zero_len_done got=%b want=001", {busy, cpu_rst, done});
        end
    endtask

    task automatic test_load_wrap();
        logic [5:0] expw;
        for (int i = 0; i < 32; i++) load_word(5'(i), {1'b0, 6'(i) ^ 6'h15});
        start_run(8'd40);
        tick();
        for (int k = 0; k < 40; k++) begin
            expw = 6'(k % 32) ^ 6'h15;
            checks++; if (cpu_instr !== expw) begin
                errors++; $display("FAIL wrap_k%0d got=%h want=%h", k, cpu_instr, expw);
            end
            load_we   = (k == 1) || (k == 2);
            load_addr = 5'd5;
            load_data = 7'h7F;
            tick();
        end
        load_we = 1'b0;
        checks++; if ({done, res_valid, overflow} !== 3'b100) begin
            errors++; $display("FAIL wrap_done got=%b want=100", {done, res_valid, overflow});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_basic_run();
        test_branch();
        test_overflow();
        test_full_pop();
        test_abort();
        test_load_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
